slave_i2c: RTL

- I2C target (responder) for our I2C master; answers a single 7-bit address on the bus.
- Oversamples SCL/SDA with the system clock, detects START/STOP, ACKs its address, and receives write bytes onto a parallel output.
- Returns read bytes from a parallel input, driving SDA open-drain.
- Does not stretch SCL. Standard-mode framing, multi-byte transfers, repeated START.

---
 rtl/slave_i2c.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/slave_i2c.sv
// I2C target at a single 7-bit address: oversampled SCL/SDA, START/STOP detection,
// address/data ACK, byte receive to rx_data and byte transmit from tx_data (open-drain SDA).
module slave_i2c #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       addressed
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;

    logic [2:0] bit_cnt, bit_cnt_nxt, bit_dec;
    logic [7:0] shreg, shreg_nxt, byte_in;
    logic       rw, rw_nxt;
    logic       phase, phase_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, tx_req_nxt, busy_nxt, addressed_nxt;
    logic       addr_match;

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Idle bus is high, so the conditioning flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign sda_rise  = sda_s & ~sda_d;
    assign sda_fall  = ~sda_s & sda_d;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    assign byte_in    = {shreg[6:0], sda_s};
    assign bit_dec    = bit_cnt - 3'd1;
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:      if (scl_rise && bit_cnt == 3'd0)
                               state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  if (scl_fall && phase) state_nxt = rw ? READ : WRITE;
                WRITE:     if (scl_rise && bit_cnt == 3'd0) state_nxt = WRITE_ACK;
                WRITE_ACK: if (scl_fall && phase) state_nxt = WRITE;
                READ:      if (scl_fall && bit_cnt == 3'd0) state_nxt = READ_ACK;
                READ_ACK: begin
                    if (scl_rise && sda_s)      state_nxt = WAIT_STOP;
                    else if (scl_fall && phase) state_nxt = READ;
                end
                default: ;
            endcase
        end
    end

    // phase marks the second half of an ACK slot (ACK driven, or master ACK seen).
    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        rw_nxt        = rw;
        phase_nxt     = phase;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        busy_nxt      = busy;
        addressed_nxt = addressed;
        if (start_det) begin
            bit_cnt_nxt   = 3'd7;
            phase_nxt     = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b1;
            addressed_nxt = 1'b0;
        end else if (stop_det) begin
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            addressed_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_nxt = byte_in;
                    if (bit_cnt == 3'd0) begin
                        rw_nxt        = sda_s;
                        phase_nxt     = 1'b0;
                        addressed_nxt = addr_match;
                    end else begin
                        bit_cnt_nxt = bit_dec;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_nxt = 1'b1;
                        phase_nxt  = 1'b1;
                    end else if (rw) begin
                        shreg_nxt   = tx_data;
                        tx_req_nxt  = 1'b1;
                        sda_oe_nxt  = ~tx_data[7];
                        bit_cnt_nxt = 3'd7;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd7;
                    end
                end
                WRITE: if (scl_rise) begin
                    shreg_nxt = byte_in;
                    if (bit_cnt == 3'd0) begin
                        rx_data_nxt  = byte_in;
                        rx_valid_nxt = 1'b1;
                        phase_nxt    = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_dec;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_nxt = 1'b1;
                        phase_nxt  = 1'b1;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd7;
                    end
                end
                READ: if (scl_fall) begin
                    if (bit_cnt == 3'd0) begin
                        sda_oe_nxt = 1'b0;
                        phase_nxt  = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_dec;
                        sda_oe_nxt  = ~shreg[bit_dec];
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !sda_s) phase_nxt = 1'b1;
                    if (scl_fall && phase) begin
                        shreg_nxt   = tx_data;
                        tx_req_nxt  = 1'b1;
                        sda_oe_nxt  = ~tx_data[7];
                        bit_cnt_nxt = 3'd7;
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            rw        <= 1'b0;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            rw        <= rw_nxt;
            phase     <= phase_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
            addressed <= addressed_nxt;
        end
    end
endmodule
